// File: rtl/bcd_count_display_pkg.sv
// Shared types and BCD helpers for the BCD event counter / serial display driver.
package bcd_count_display_pkg;

  localparam int         NIBBLE_W = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  typedef enum logic {
    CNT_IDLE,
    CNT_RIPPLE
  } cnt_state_t;

  typedef enum logic [1:0] {
    SHF_IDLE,
    SHF_LOW,
    SHF_HIGH,
    SHF_LATCH
  } shf_state_t;

  // Adds 0..2 to one BCD digit; returns {carry_out, new_digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] digit, input logic [1:0] add);
    logic [4:0] sum;
    sum = {1'b0, digit} + {3'b000, add};
    if (sum > {1'b0, BCD_MAX}) begin
      bcd_digit_add = {1'b1, sum[3:0] - 4'd10};
    end else begin
      bcd_digit_add = {1'b0, sum[3:0]};
    end
  endfunction

endpackage

// File: rtl/bcd_count_display_if.sv
// Strobe inputs and serial display bus of the BCD counter/display block.
interface bcd_count_display_if #(
  parameter int DIGITS = 6
);

  logic [DIGITS-1:0] trigger;
  logic              inc_pulse;
  logic              ref_pulse;
  logic              ser_data;
  logic              ser_clk;
  logic              ser_latch;
  logic              busy;
  logic              overflow;

  modport master (
    output trigger, inc_pulse, ref_pulse,
    input  ser_data, ser_clk, ser_latch, busy, overflow
  );

  modport slave (
    input  trigger, inc_pulse, ref_pulse,
    output ser_data, ser_clk, ser_latch, busy, overflow
  );

endinterface

// File: rtl/bcd_count_display_serial_shift_out.sv
// Serial frame shifter: snapshots a parallel word on a refresh strobe and
// shifts it out MSB first with a divided shift clock, then pulses latch.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// SHF_IDLE  | no frame; outputs low, waiting for a refresh strobe
// SHF_LOW   | shift clock low, current MSB driven on ser_data
// SHF_HIGH  | shift clock high, display samples ser_data
// SHF_LATCH | all bits sent, latch pulse high; may chain a pending frame
module serial_shift_out
  import bcd_count_display_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] snapshot,
  input  logic             ref_pulse,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic             busy
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int               BIT_W    = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WIDTH);

  shf_state_t       state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             pending, pending_nxt;
  logic             ref_q;
  logic             data_nxt, clk_nxt, latch_nxt, busy_nxt;
  logic             div_done;

  // Register the strobe so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ref_q <= 1'b0;
    else       ref_q <= ref_pulse;
  end

  // State, timers, shift register and registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SHF_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      pending   <= 1'b0;
      ser_data  <= 1'b0;
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= shreg_nxt;
      pending   <= pending_nxt;
      ser_data  <= data_nxt;
      ser_clk   <= clk_nxt;
      ser_latch <= latch_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and next-output decode; the half-period timer is a down-counter.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    bit_nxt     = bit_cnt;
    shreg_nxt   = shreg;
    pending_nxt = pending;
    data_nxt    = ser_data;
    clk_nxt     = ser_clk;
    latch_nxt   = ser_latch;
    busy_nxt    = busy;
    div_done    = (div_cnt == '0);

    case (state)
      SHF_IDLE: begin
        if (ref_q) begin
          state_nxt = SHF_LOW;
          shreg_nxt = snapshot;
          bit_nxt   = BIT_LOAD;
          div_nxt   = DIV_LOAD;
          data_nxt  = snapshot[WIDTH-1];
          clk_nxt   = 1'b0;
          busy_nxt  = 1'b1;
        end
      end

      SHF_LOW: begin
        pending_nxt = pending | ref_q;
        if (div_done) begin
          state_nxt = SHF_HIGH;
          div_nxt   = DIV_LOAD;
          clk_nxt   = 1'b1;
        end else begin
          div_nxt = div_cnt - 1'b1;
        end
      end

      SHF_HIGH: begin
        pending_nxt = pending | ref_q;
        if (div_done) begin
          shreg_nxt = shreg << 1;
          bit_nxt   = bit_cnt - 1'b1;
          div_nxt   = DIV_LOAD;
          clk_nxt   = 1'b0;
          if (bit_cnt == BIT_W'(1)) begin
            state_nxt = SHF_LATCH;
            data_nxt  = 1'b0;
            latch_nxt = 1'b1;
          end else begin
            state_nxt = SHF_LOW;
            data_nxt  = shreg[WIDTH-2];
          end
        end else begin
          div_nxt = div_cnt - 1'b1;
        end
      end

      SHF_LATCH: begin
        if (div_done) begin
          latch_nxt   = 1'b0;
          pending_nxt = 1'b0;
          // A refresh that arrived mid-frame chains straight into a new frame.
          if (pending | ref_q) begin
            state_nxt = SHF_LOW;
            shreg_nxt = snapshot;
            bit_nxt   = BIT_LOAD;
            div_nxt   = DIV_LOAD;
            data_nxt  = snapshot[WIDTH-1];
          end else begin
            state_nxt = SHF_IDLE;
            busy_nxt  = 1'b0;
          end
        end else begin
          div_nxt     = div_cnt - 1'b1;
          pending_nxt = pending | ref_q;
        end
      end

      default: begin
        state_nxt = SHF_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/bcd_count_display.sv
// BCD event counter with ripple-carry digit update and a serial display output.
//
// state      | meaning
// -----------+----------------------------------------------------------
// CNT_IDLE   | waiting for an increment strobe
// CNT_RIPPLE | adding the captured mask one digit per cycle, LSD first
module bcd_count_display
  import bcd_count_display_pkg::*;
#(
  parameter int DIGITS  = 6,
  parameter int CLK_DIV = 4
) (
  input logic           clk,
  input logic           reset,
  bcd_count_display_if.slave bus
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIGITS-1:0][NIBBLE_W-1:0] digit, digit_nxt;
  logic [NIBBLE_W*DIGITS-1:0]      snapshot;
  cnt_state_t                      cnt_state, cnt_state_nxt;
  logic [IDX_W-1:0]                idx, idx_nxt;
  logic                            carry, carry_nxt;
  logic [DIGITS-1:0]               mask, mask_nxt;
  logic                            overflow_q, overflow_nxt;
  logic [4:0]                      add_res;

  // Counter state, digit registers and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_state  <= CNT_IDLE;
      digit      <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      mask       <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_state  <= cnt_state_nxt;
      digit      <= digit_nxt;
      idx        <= idx_nxt;
      carry      <= carry_nxt;
      mask       <= mask_nxt;
      overflow_q <= overflow_nxt;
    end
  end

  // Ripple engine: one digit per cycle, later increment strobes ignored until done.
  always_comb begin
    cnt_state_nxt = cnt_state;
    digit_nxt     = digit;
    idx_nxt       = idx;
    carry_nxt     = carry;
    mask_nxt      = mask;
    overflow_nxt  = overflow_q;
    add_res       = '0;

    case (cnt_state)
      CNT_IDLE: begin
        if (bus.inc_pulse) begin
          cnt_state_nxt = CNT_RIPPLE;
          mask_nxt      = bus.trigger;
          idx_nxt       = '0;
          carry_nxt     = 1'b0;
        end
      end

      CNT_RIPPLE: begin
        add_res        = bcd_digit_add(digit[idx], {1'b0, mask[idx]} + {1'b0, carry});
        digit_nxt[idx] = add_res[3:0];
        carry_nxt      = add_res[4];
        if (idx == LAST_IDX) begin
          cnt_state_nxt = CNT_IDLE;
          if (add_res[4]) overflow_nxt = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end

      default: begin
        cnt_state_nxt = CNT_IDLE;
      end
    endcase
  end

  assign snapshot     = digit;
  assign bus.overflow = overflow_q;

  serial_shift_out #(
    .WIDTH   (NIBBLE_W * DIGITS),
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk       (clk),
    .reset     (reset),
    .snapshot  (snapshot),
    .ref_pulse (bus.ref_pulse),
    .ser_data  (bus.ser_data),
    .ser_clk   (bus.ser_clk),
    .ser_latch (bus.ser_latch),
    .busy      (bus.busy)
  );

endmodule

// File: tb/tb_bcd_count_display.sv
// Directed bench: frames are checked by a latch-triggered scoreboard monitor,
// ripple timing and flags are checked inline against hand-computed values.
module tb_bcd_count_display;

  localparam int DIGITS  = 6;
  localparam int CLK_DIV = 4;
  localparam int WIDTH   = 4 * DIGITS;

  logic clk = 1'b0;
  logic reset;

  bcd_count_display_if #(.DIGITS(DIGITS)) bus();

  bcd_count_display #(
    .DIGITS  (DIGITS),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int               total = 0;
  int               bad = 0;
  int               latch_count = 0;
  int               bit_count = 0;
  int               lc;
  logic [WIDTH-1:0] shbuf = '0;
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] exp_frame;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Monitor: assemble bits on each shift-clock rise.
  always @(posedge bus.ser_clk) begin
    shbuf = {shbuf[WIDTH-2:0], bus.ser_data};
    bit_count++;
  end

  // Monitor: each latch pulse closes a frame and is checked against the scoreboard.
  always @(posedge bus.ser_latch) begin
    latch_count++;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_frame: got %h expected none", shbuf);
    end else begin
      exp_frame = sb_q.pop_front();
      total--;
      check("frame_data", 32'(shbuf), 32'(exp_frame));
      check("frame_bits", bit_count, WIDTH);
    end
    bit_count = 0;
  end

  // A reset aborts any frame in flight, so its expectation is dropped.
  always @(posedge reset) begin
    bit_count = 0;
    sb_q.delete();
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input logic [DIGITS-1:0] m);
    bus.trigger   = m;
    bus.inc_pulse = 1'b1;
    tick(1);
    bus.inc_pulse = 1'b0;
  endtask

  task automatic pulse_ref(input logic expect_frame, input logic [WIDTH-1:0] exp);
    if (expect_frame) sb_q.push_back(exp);
    bus.ref_pulse = 1'b1;
    tick(1);
    bus.ref_pulse = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < 2000) begin
      tick(1);
      n++;
    end
    check(name, bus.busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.trigger   = '0;
    bus.inc_pulse = 1'b0;
    bus.ref_pulse = 1'b0;
    tick(3);
    check("reset_outputs", {bus.ser_data, bus.ser_clk, bus.ser_latch, bus.busy, bus.overflow}, 0);
    check("reset_digits", dut.digit, 0);
    reset = 1'b0;
    tick(1);

    // Single increment and full frame timing.
    pulse_inc(6'b000001);
    tick(6);
    check("inc1_count", dut.digit, 24'h000001);
    pulse_ref(1'b1, 24'h000001);
    tick(1);
    check("busy_r1", bus.busy, 1);
    tick(3);
    check("sclk_low_r4", bus.ser_clk, 0);
    tick(1);
    check("sclk_rise_r5", bus.ser_clk, 1);
    tick(188);
    check("latch_r193", bus.ser_latch, 1);
    tick(3);
    check("busy_r196", bus.busy, 1);
    tick(1);
    check("busy_fall_r197", bus.busy, 0);
    check("latch_low_r197", bus.ser_latch, 0);
    check("latch_count_1", latch_count, 1);

    // Reset in the middle of a frame.
    lc = latch_count;
    pulse_ref(1'b1, 24'h000001);
    tick(50);
    #2 reset = 1'b1;
    #1;
    check("midreset_outputs", {bus.ser_data, bus.ser_clk, bus.ser_latch, bus.busy, bus.overflow}, 0);
    check("midreset_digits", dut.digit, 0);
    tick(3);
    reset = 1'b0;
    tick(2);
    check("midreset_no_latch", latch_count, lc);
    pulse_ref(1'b1, 24'h000000);
    tick(1);
    wait_idle("zero_frame_idle");
    check("zero_frame_latched", latch_count, lc + 1);

    // Carry across two digits: 000099 + 000011.
    for (int k = 0; k < 9; k++) begin
      pulse_inc(6'b000011);
      tick(8);
    end
    check("count_99", dut.digit, 24'h000099);
    pulse_inc(6'b000011);
    tick(1);
    check("ripple_t1", dut.digit, 24'h000090);
    tick(1);
    check("ripple_t2", dut.digit, 24'h000010);
    tick(1);
    check("ripple_t3", dut.digit, 24'h000110);
    tick(3);
    check("ripple_t6", dut.digit, 24'h000110);
    check("no_overflow", bus.overflow, 0);
    pulse_ref(1'b1, 24'h000110);
    tick(1);
    wait_idle("frame110_idle");

    // Wrap 999999 -> 000000 with sticky overflow.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      pulse_inc(6'b111111);
      tick(8);
    end
    check("count_999999", dut.digit, 24'h999999);
    pulse_inc(6'b000001);
    tick(5);
    check("wrap_t5_digits", dut.digit, 24'h900000);
    check("wrap_t5_ovf", bus.overflow, 0);
    tick(1);
    check("wrap_t6_digits", dut.digit, 24'h000000);
    check("wrap_t6_ovf", bus.overflow, 1);
    pulse_inc(6'b000001);
    tick(6);
    check("post_wrap_count", dut.digit, 24'h000001);
    check("ovf_sticky", bus.overflow, 1);
    pulse_ref(1'b1, 24'h000001);
    tick(1);
    wait_idle("frame_wrap_idle");

    // Pending refresh: R, R+50 (pending), R+60 (absorbed).
    lc = latch_count;
    pulse_ref(1'b1, 24'h000001);
    tick(19);
    pulse_inc(6'b000100);
    tick(29);
    pulse_ref(1'b1, 24'h000101);
    tick(9);
    pulse_ref(1'b0, 24'h000000);
    tick(136);
    check("pend_latch_r196", bus.ser_latch, 1);
    check("pend_busy_r196", bus.busy, 1);
    tick(1);
    check("pend_latch_r197", bus.ser_latch, 0);
    check("pend_busy_r197", bus.busy, 1);
    check("pend_first_done", latch_count, lc + 1);
    wait_idle("pend_idle");
    check("pend_two_frames", latch_count, lc + 2);
    tick(300);
    check("pend_no_third", latch_count, lc + 2);

    // Second increment strobe during ripple is ignored.
    pulse_inc(6'b000001);
    tick(2);
    pulse_inc(6'b000010);
    tick(10);
    check("ignored_inc", dut.digit, 24'h000102);
    pulse_ref(1'b1, 24'h000102);
    tick(1);
    wait_idle("frame102_idle");

    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
